fetch_pc_ctrl: RTL and testbench
================================

FETCH_PC_CTRL -- requirements
Module: fetch_pc_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'hBFC00000, address of the first fetch after reset.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 stallF  in  1  hazard stall; F/D handoff is blocked while high.
REQ-005 flushF  in  1  exception flush; restart fetch at pc_excF.
REQ-006 pc_excF  in  32  exception vector.
REQ-007 jumpD, jump_conflictD  in  1 each  jump present in D; target not yet valid.
REQ-008 pc_jumpD  in  32  jump target from D.
REQ-009 branch_takenD  in  1  resolved taken branch in D.
REQ-010 pc_branchD  in  32  branch target.
REQ-011 stallD  in  1  D stage held this cycle.
REQ-012 inst_req  out  1  instruction-bus request.
REQ-013 inst_addr  out  32  request address, equal to pcF.
REQ-014 inst_addr_ok  in  1  address accepted.
REQ-015 inst_data_ok  in  1  read data returned.
REQ-016 inst_rdata  in  32  read data.
REQ-017 pcF, pc_plus4F  out  32  F-stage PC and PC+4.
REQ-018 instrF  out  32  fetched instruction.
REQ-019 instr_validF  out  1  instrF/pcF valid for handoff to D.

Function
REQ-020 The block SHALL run a 3-state FSM: S_REQ (inst_req=1), S_WAIT (address accepted, data outstanding), S_HOLD (data held, awaiting handoff).
REQ-021 S_REQ SHALL go to S_WAIT on inst_addr_ok; otherwise stay in S_REQ.
REQ-022 S_WAIT SHALL, on inst_data_ok without discard, register inst_rdata into instrF, set instr_validF the next cycle and enter S_HOLD.
REQ-023 Handoff SHALL occur at a clock edge where instr_validF=1 and stallF=0; at that edge instr_validF clears, pcF loads next-PC and state becomes S_REQ.
REQ-024 Redirect SHALL be accepted when ((jumpD & ~jump_conflictD) | branch_takenD) & ~stallD; jumpD with jump_conflictD=1 SHALL NOT redirect.
REQ-025 Branch target SHALL take priority over jump target when both are asserted.
REQ-026 Delay slot: the instruction in F at redirect is the delay slot and SHALL still be delivered; the target SHALL be held in pend_pc/pend_v until the next handoff.
REQ-027 Next-PC priority SHALL be: flushF -> pc_excF; pend_v -> pend_pc; redirect this cycle -> its target; else pcF+4 (32-bit wrap).
REQ-028 pend_v SHALL clear on the handoff that consumes it, and on flushF.
REQ-029 flushF SHALL, at that edge, load pcF=pc_excF, clear instr_validF and pend_v, and enter S_REQ.
REQ-030 If flushF occurs in S_WAIT, or in S_REQ with inst_addr_ok that cycle, a discard flag SHALL be set; the next inst_data_ok SHALL be dropped and the flag cleared.
REQ-031 Only one request SHALL be outstanding; inst_req SHALL be 0 in S_WAIT and S_HOLD.
REQ-032 inst_addr MAY change while in S_REQ before inst_addr_ok; it SHALL NOT change after acceptance.
REQ-033 inst_data_ok while discard is set and inst_addr_ok the same cycle SHALL drop the old data and accept the new address.

Reset
REQ-034 On rst, outputs SHALL be: pcF=RESET_PC, pc_plus4F=RESET_PC+4, instrF=0, instr_validF=0, inst_req=0.
REQ-035 On rst, internal state SHALL be: state S_REQ, pend_v=0, discard=0; inst_req SHALL rise the first cycle after rst deasserts.
REQ-036 Reset asserted mid-transaction SHALL abandon it without discard; the bus is reset together with this block.

Structure
REQ-037 FSM state encodings and RESET_PC default SHALL live in the shared CPU defines package.
REQ-038 No sub-module; the block SHALL be a single module.

Verification
REQ-039 Reset release, addr_ok and data_ok after 1 cycle, data 0x24010001 -> first inst_addr 0xBFC00000; instr_validF high 2 cycles after addr_ok; next inst_addr 0xBFC00004.
REQ-040 jumpD=1, pc_jumpD=0x80001000, conflict=0, while delay slot 0xBFC00008 is in S_WAIT -> delay slot delivered; next inst_addr 0x80001000.
REQ-041 jumpD=1 with jump_conflictD=1 for 2 cycles, then conflict=0 -> no redirect during conflict; target taken when conflict clears.
REQ-042 flushF=1, pc_excF=0xBFC00380, in S_WAIT -> returned data dropped, instr_validF stays 0, next inst_addr 0xBFC00380.
REQ-043 stallF=1 for 3 cycles with instr_validF=1 -> pcF/instrF stable, inst_req=0; handoff on release.

Source files
------------

// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared CPU fetch definitions: fetch FSM encodings and the boot address.
package fetch_pc_ctrl_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage PC control: one-outstanding instruction-bus requester with
// delay-slot-aware redirect, exception flush and stale-response discard.
module fetch_pc_ctrl
    import fetch_pc_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallF,
    input  logic        flushF,
    input  logic [31:0] pc_excF,
    input  logic        jumpD,
    input  logic        jump_conflictD,
    input  logic [31:0] pc_jumpD,
    input  logic        branch_takenD,
    input  logic [31:0] pc_branchD,
    input  logic        stallD,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic [31:0] pcF,
    output logic [31:0] pc_plus4F,
    output logic [31:0] instrF,
    output logic        instr_validF
);

    fetch_state_e state;
    fetch_state_e state_next;

    logic [31:0] pend_pc;
    logic        pend_v;
    logic        discard;

    logic        redirect;
    logic [31:0] redirect_pc;
    logic        handoff;
    logic        data_accept;
    logic [31:0] next_pc;

    assign redirect    = ((jumpD & ~jump_conflictD) | branch_takenD) & ~stallD;
    assign redirect_pc = branch_takenD ? pc_branchD : pc_jumpD;
    assign handoff     = instr_validF & ~stallF;
    assign data_accept = (state == S_WAIT) & inst_data_ok & ~discard;

    assign inst_addr = pcF;
    assign pc_plus4F = pcF + PC_STEP;

    always_comb begin
        next_pc = pcF + PC_STEP;
        if (flushF) begin
            next_pc = pc_excF;
        end else if (pend_v) begin
            next_pc = pend_pc;
        end else if (redirect) begin
            next_pc = redirect_pc;
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_REQ;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: default assignment first so no path through this block infers a latch.
    always_comb begin
        state_next = state;
        if (flushF) begin
            state_next = S_REQ;
        end else begin
            unique case (state)
                S_REQ:   if (inst_addr_ok) state_next = S_WAIT;
                S_WAIT:  if (data_accept)  state_next = S_HOLD;
                S_HOLD:  if (handoff)      state_next = S_REQ;
                default:                   state_next = S_REQ;
            endcase
        end
    end

    always_comb begin
        inst_req = (state == S_REQ) & ~rst;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcF          <= RESET_PC;
            instrF       <= '0;
            instr_validF <= 1'b0;
            pend_pc      <= '0;
            pend_v       <= 1'b0;
            discard      <= 1'b0;
        end else begin
            if (flushF | handoff) begin
                pcF <= next_pc;
            end

            if (data_accept & ~flushF) begin
                instrF <= inst_rdata;
            end

            if (flushF | handoff) begin
                instr_validF <= 1'b0;
            end else if (data_accept) begin
                instr_validF <= 1'b1;
            end

            // A redirect while the delay slot is still in flight waits for its handoff.
            if (flushF | handoff) begin
                pend_v <= 1'b0;
            end else if (redirect) begin
                pend_v  <= 1'b1;
                pend_pc <= redirect_pc;
            end

            // A response arriving in the flush cycle itself is the one being dropped.
            if (flushF && (((state == S_WAIT) && (discard || !inst_data_ok)) ||
                           ((state == S_REQ) && inst_addr_ok))) begin
                discard <= 1'b1;
            end else if (inst_data_ok) begin
                discard <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Scoreboard bench for fetch_pc_ctrl: directed pipeline events against a
// bus responder, with request and handoff monitors popping expected queues.
module tb_fetch_pc_ctrl;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } hand_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallF;
    logic        flushF;
    logic [31:0] pc_excF;
    logic        jumpD;
    logic        jump_conflictD;
    logic [31:0] pc_jumpD;
    logic        branch_takenD;
    logic [31:0] pc_branchD;
    logic        stallD;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok = 1'b0;
    logic        inst_data_ok = 1'b0;
    logic [31:0] inst_rdata   = '0;
    logic [31:0] pcF;
    logic [31:0] pc_plus4F;
    logic [31:0] instrF;
    logic        instr_validF;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_addr_q[$];
    hand_t       exp_hand_q[$];
    hand_t       mon_h;

    logic [31:0] bus_q[$];
    bit          bus_accept_en;
    bit          bus_data_hold;
    logic        prev_req_acc = 1'b0;
    logic        prev_data_ok = 1'b0;
    logic [31:0] prev_addr    = '0;

    fetch_pc_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .stallF         (stallF),
        .flushF         (flushF),
        .pc_excF        (pc_excF),
        .jumpD          (jumpD),
        .jump_conflictD (jump_conflictD),
        .pc_jumpD       (pc_jumpD),
        .branch_takenD  (branch_takenD),
        .pc_branchD     (pc_branchD),
        .stallD         (stallD),
        .inst_req       (inst_req),
        .inst_addr      (inst_addr),
        .inst_addr_ok   (inst_addr_ok),
        .inst_data_ok   (inst_data_ok),
        .inst_rdata     (inst_rdata),
        .pcF            (pcF),
        .pc_plus4F      (pc_plus4F),
        .instrF         (instrF),
        .instr_validF   (instr_validF)
    );

    always #5 clk = ~clk;

    // Memory image: the word at 0xBFC00000 is 0x24010001.
    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        return a ^ 32'h9BC1_0001;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic wait_s_wait(input logic [31:0] addr);
        int i = 0;
        while (!(inst_addr == addr && !inst_req && !instr_validF) && i < 60) begin
            @(negedge clk);
            i++;
        end
        if (i >= 60) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_s_wait: no wait state for %08h within 60 cycles", addr);
        end
    endtask

    task automatic wait_valid(input logic [31:0] addr);
        int i = 0;
        while (!(instr_validF && pcF == addr) && i < 60) begin
            @(negedge clk);
            i++;
        end
        if (i >= 60) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_valid: %08h never became valid within 60 cycles", addr);
        end
    endtask

    // Bus responder: accepts every request at once, returns data in order one
    // cycle or more after acceptance unless held.
    always @(negedge clk) begin
        #1;
        if (rst) begin
            bus_q.delete();
            inst_addr_ok = 1'b0;
            inst_data_ok = 1'b0;
            inst_rdata   = '0;
            prev_req_acc = 1'b0;
            prev_data_ok = 1'b0;
        end else begin
            if (prev_data_ok && bus_q.size() > 0) void'(bus_q.pop_front());
            if (prev_req_acc) bus_q.push_back(prev_addr);
            inst_addr_ok = inst_req && bus_accept_en;
            inst_data_ok = (bus_q.size() > 0) && !bus_data_hold;
            inst_rdata   = inst_data_ok ? rdata_of(bus_q[0]) : 32'h0;
            prev_req_acc = inst_req && inst_addr_ok;
            prev_addr    = inst_addr;
            prev_data_ok = inst_data_ok;
        end
    end

    // Monitor: every accepted request and every F/D handoff pops the scoreboard.
    always @(negedge clk) begin
        #3;
        if (!rst) begin
            if (inst_req && inst_addr_ok) begin
                if (exp_addr_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL req_addr: unexpected request to %08h", inst_addr);
                end else begin
                    check("req_addr", inst_addr, exp_addr_q.pop_front());
                end
            end
            if (instr_validF && !stallF) begin
                if (exp_hand_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL handoff: unexpected handoff pc %08h instr %08h", pcF, instrF);
                end else begin
                    mon_h = exp_hand_q.pop_front();
                    check("handoff_pc", pcF, mon_h.pc);
                    check("handoff_instr", instrF, mon_h.instr);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        rst = 1'b1; stallF = 1'b0; flushF = 1'b0; pc_excF = '0;
        jumpD = 1'b0; jump_conflictD = 1'b0; pc_jumpD = '0;
        branch_takenD = 1'b0; pc_branchD = '0; stallD = 1'b0;
        bus_accept_en = 1'b1; bus_data_hold = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_pcF", pcF, 32'hBFC0_0000);
        check("rst_pc_plus4F", pc_plus4F, 32'hBFC0_0004);
        check("rst_instrF", instrF, 32'h0);
        check("rst_valid", {31'b0, instr_validF}, 32'h0);
        check("rst_inst_req", {31'b0, inst_req}, 32'h0);

        foreach (exp_addr_q[i]) exp_addr_q.delete();
        exp_addr_q.push_back(32'hBFC0_0000);
        exp_addr_q.push_back(32'hBFC0_0004);
        exp_addr_q.push_back(32'hBFC0_0008);
        exp_addr_q.push_back(32'h8000_1000);
        exp_addr_q.push_back(32'h8000_1004);
        exp_addr_q.push_back(32'h8000_1008);
        exp_addr_q.push_back(32'h8000_2000);
        exp_addr_q.push_back(32'h8000_2004);
        exp_addr_q.push_back(32'hBFC0_0380);
        exp_addr_q.push_back(32'hBFC0_0400);
        exp_addr_q.push_back(32'hBFC0_0404);
        exp_hand_q.push_back('{pc: 32'hBFC0_0000, instr: 32'h2401_0001});
        exp_hand_q.push_back('{pc: 32'hBFC0_0004, instr: rdata_of(32'hBFC0_0004)});
        exp_hand_q.push_back('{pc: 32'hBFC0_0008, instr: rdata_of(32'hBFC0_0008)});
        exp_hand_q.push_back('{pc: 32'h8000_1000, instr: rdata_of(32'h8000_1000)});
        exp_hand_q.push_back('{pc: 32'h8000_1004, instr: rdata_of(32'h8000_1004)});
        exp_hand_q.push_back('{pc: 32'h8000_1008, instr: rdata_of(32'h8000_1008)});
        exp_hand_q.push_back('{pc: 32'h8000_2000, instr: rdata_of(32'h8000_2000)});
        exp_hand_q.push_back('{pc: 32'hBFC0_0380, instr: 32'h2401_0381});
        exp_hand_q.push_back('{pc: 32'hBFC0_0400, instr: rdata_of(32'hBFC0_0400)});

        // Boot fetch: request right after reset, valid two cycles after acceptance.
        rst = 1'b0;
        #1;
        check("boot_inst_req", {31'b0, inst_req}, 32'h1);
        check("boot_inst_addr", inst_addr, 32'hBFC0_0000);
        @(negedge clk);
        check("boot_valid_c1", {31'b0, instr_validF}, 32'h0);
        @(negedge clk);
        check("boot_valid_c2", {31'b0, instr_validF}, 32'h1);
        check("boot_instrF", instrF, 32'h2401_0001);

        // Jump while the delay slot is outstanding.
        wait_s_wait(32'hBFC0_0008);
        jumpD = 1'b1; pc_jumpD = 32'h8000_1000;
        @(negedge clk);
        jumpD = 1'b0; pc_jumpD = '0;
        check("delay_slot_pcF", pcF, 32'hBFC0_0008);
        @(negedge clk);
        check("jump_target_pcF", pcF, 32'h8000_1000);

        // Jump held off by a conflict across a handoff, then taken.
        wait_s_wait(32'h8000_1004);
        jumpD = 1'b1; jump_conflictD = 1'b1; pc_jumpD = 32'h8000_2000;
        @(negedge clk);
        @(negedge clk);
        check("conflict_no_redirect", pcF, 32'h8000_1008);
        jump_conflictD = 1'b0;
        @(negedge clk);
        jumpD = 1'b0; pc_jumpD = '0;
        check("accepted_addr_stable", pcF, 32'h8000_1008);

        // Flush with a response outstanding; the stale data returns alongside the new request.
        wait_s_wait(32'h8000_2004);
        flushF = 1'b1; pc_excF = 32'hBFC0_0380; bus_data_hold = 1'b1;
        @(negedge clk);
        flushF = 1'b0; bus_data_hold = 1'b0;
        check("flush_valid_c1", {31'b0, instr_validF}, 32'h0);
        check("flush_inst_addr", inst_addr, 32'hBFC0_0380);
        @(negedge clk);
        check("flush_valid_c2", {31'b0, instr_validF}, 32'h0);

        // Three-cycle F stall with a branch (beating a jump) and a stalled-D branch.
        wait_valid(32'hBFC0_0380);
        stallF = 1'b1;
        branch_takenD = 1'b1; pc_branchD = 32'hBFC0_0400;
        jumpD = 1'b1; pc_jumpD = 32'h1234_5678;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c == 0) begin
                jumpD = 1'b0; pc_jumpD = '0;
                pc_branchD = 32'hDEAD_0000; stallD = 1'b1;
            end else begin
                branch_takenD = 1'b0; pc_branchD = '0; stallD = 1'b0;
            end
            if (c == 2) stallF = 1'b0;
            check("stall_pcF", pcF, 32'hBFC0_0380);
            check("stall_instrF", instrF, 32'h2401_0381);
            check("stall_valid", {31'b0, instr_validF}, 32'h1);
            check("stall_inst_req", {31'b0, inst_req}, 32'h0);
        end
        @(negedge clk);
        check("branch_target_pcF", pcF, 32'hBFC0_0400);

        for (int i = 0; i < 100 && (exp_addr_q.size() != 0 || exp_hand_q.size() != 0); i++) begin
            @(negedge clk);
        end
        stallF = 1'b1;
        bus_accept_en = 1'b0;
        repeat (4) @(negedge clk);
        check("addr_queue_drained", exp_addr_q.size(), 32'd0);
        check("hand_queue_drained", exp_hand_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
